// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types for the packet-generator front end.
//   pkt_hdr_t   : header bundle handed from a requester to the packet
//                 generator (MAC / IP / UDP addresses plus alternates).
//   arb_state_t : state encoding of the gen_packet_arbiter FSM.
//   HDR_W       : width of pkt_hdr_t in bits.
// ---------------------------------------------------------------------------
package router_pkg;

    typedef struct packed {
        logic [47:0] dest_addr;
        logic [47:0] src_addr;
        logic [47:0] alt_dest_addr;
        logic [47:0] alt_src_addr;
        logic [31:0] ip_dest_addr;
        logic [31:0] ip_src_addr;
        logic [31:0] alt_ip_dest_addr;
        logic [31:0] alt_ip_src_addr;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_src_port;
        logic [15:0] alt_udp_dest_port;
        logic [15:0] alt_udp_src_port;
        logic        encapsulated;
    } pkt_hdr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int HDR_W = $bits(pkt_hdr_t);

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches the request vector starting
// at the requester after 'last' and wrapping around, returning the index of
// the first active request. When no request is active the output is 'last'
// and is ignored by the caller.
// Ports:
//   req   [NUM_REQ-1:0]        in  : active requests
//   last  [clog2(NUM_REQ)-1:0] in  : most recently granted index
//   grant [clog2(NUM_REQ)-1:0] out : selected index
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin : search
        int unsigned idx;
        logic        found;
        grant = last;
        found = 1'b0;
        idx   = 0;
        // Offsets 1..NUM_REQ so 'last' itself is checked only after every
        // other requester, which gives the rotating priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gen_packet_arbiter.sv
// ---------------------------------------------------------------------------
// gen_packet_arbiter
// Picks one of NUM_REQ header requesters round-robin, latches its header,
// presents it to the packet generator with a valid/ready handshake and then
// waits for the end of the generated packet on the monitored data stream.
//
// Optional feature (macro GEN_PACKET_ARB_TIMEOUT_EN): packet watchdog. A
// cycle counter runs through ISSUE and BUSY; when it reaches
// TIMEOUT_CYCLES-1 the block pulses gen_flush, bumps timeout_count
// (saturating) and returns to IDLE. Without the macro gen_flush and
// timeout_count are constant 0.
//
// Ports:
//   axis_clk, axis_reset       : clock, synchronous active-high reset
//   req_valid/req_hdr/req_ack  : requester side (ack = 1-cycle latch pulse)
//   gen_hdr/gen_valid/gen_ready: header handshake to the generator
//   gen_flush                  : payload FIFO flush on watchdog expiry
//   txd_tvalid/tready/tlast    : taps on the generator output stream
//   busy, grant_idx            : status (not IDLE, last granted index)
//   pkt_count, timeout_count   : completed packets, watchdog expiries
// ---------------------------------------------------------------------------
module gen_packet_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       axis_clk,
    input  logic                       axis_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  pkt_hdr_t [NUM_REQ-1:0]     req_hdr,
    output logic [NUM_REQ-1:0]         req_ack,
    output pkt_hdr_t                   gen_hdr,
    output logic                       gen_valid,
    input  logic                       gen_ready,
    output logic                       gen_flush,
    input  logic                       txd_tvalid,
    input  logic                       txd_tready,
    input  logic                       txd_tlast,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic [31:0]                pkt_count,
    output logic [15:0]                timeout_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    pkt_hdr_t           gen_hdr_q, gen_hdr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic [IDX_W-1:0]   rr_grant;
    logic               eop;
    logic               wd_expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .last  (grant_q),
        .grant (rr_grant)
    );

    assign eop = txd_tvalid & txd_tready & txd_tlast;

`ifdef GEN_PACKET_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [15:0]     to_cnt_q, to_cnt_d;

    assign wd_expire = (state_q != IDLE) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        // Held at zero in IDLE so the first ISSUE cycle is count 0.
        if (state_q == IDLE) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (wd_expire && (to_cnt_q != 16'hFFFF)) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            wd_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Masked during reset so an abandoned packet never produces a flush.
    assign gen_flush     = wd_expire & ~axis_reset;
    assign timeout_count = to_cnt_q;
`else
    assign wd_expire     = 1'b0;
    assign gen_flush     = 1'b0;
    assign timeout_count = '0;
`endif

    always_comb begin
        state_d   = state_q;
        gen_hdr_d = gen_hdr_q;
        ack_d     = '0;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d         = ISSUE;
                    gen_hdr_d       = req_hdr[rr_grant];
                    ack_d[rr_grant] = 1'b1;
                    grant_d         = rr_grant;
                end
            end
            ISSUE: begin
                if (wd_expire) begin
                    state_d = IDLE;
                end else if (gen_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Always pass through IDLE after a packet, even with
                // requests pending, so busy drops for one cycle.
                if (wd_expire) begin
                    state_d = IDLE;
                end else if (eop) begin
                    state_d   = IDLE;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state_q   <= IDLE;
            gen_hdr_q <= '0;
            ack_q     <= '0;
            grant_q   <= IDX_W'(NUM_REQ - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gen_hdr_q <= gen_hdr_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign req_ack   = ack_q;
    assign gen_hdr   = gen_hdr_q;
    assign gen_valid = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_gen_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gen_packet_arbiter
// Directed scenarios followed by randomized traffic, compared cycle by cycle
// against a behavioural model of the arbiter kept in this file. Build with
// GEN_PACKET_ARB_TIMEOUT_EN to include the watchdog scenario (limit 16).
// ---------------------------------------------------------------------------
module tb_gen_packet_arbiter;
    import router_pkg::*;

    localparam int N = 4;
`ifdef GEN_PACKET_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TB_TO = 16;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TB_TO = 65535;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       rv;
    pkt_hdr_t [N-1:0]   hdr;
    logic               gen_ready, tv, tr, tl;
    logic [N-1:0]       req_ack;
    pkt_hdr_t           gen_hdr;
    logic               gen_valid, gen_flush, busy;
    logic [1:0]         grant_idx;
    logic [31:0]        pkt_count;
    logic [15:0]        timeout_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state: phase 0 idle, 1 header offered, 2 packet running
    int          m_ph;
    int          m_last;
    int          m_wd;
    pkt_hdr_t    m_hdr;
    logic [N-1:0] m_ack;
    logic [31:0] m_pkts;
    logic [15:0] m_tos;

    gen_packet_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .axis_clk      (clk),
        .axis_reset    (rst),
        .req_valid     (rv),
        .req_hdr       (hdr),
        .req_ack       (req_ack),
        .gen_hdr       (gen_hdr),
        .gen_valid     (gen_valid),
        .gen_ready     (gen_ready),
        .gen_flush     (gen_flush),
        .txd_tvalid    (tv),
        .txd_tready    (tr),
        .txd_tlast     (tl),
        .busy          (busy),
        .grant_idx     (grant_idx),
        .pkt_count     (pkt_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic pkt_hdr_t rand_hdr();
        logic [415:0] t;
        for (int w = 0; w < 13; w++) t[w*32 +: 32] = $urandom;
        return pkt_hdr_t'(t[HDR_W-1:0]);
    endfunction

    task automatic model_next();
        if (rst) begin
            m_ph = 0; m_last = N - 1; m_wd = 0;
            m_hdr = '0; m_ack = '0; m_pkts = '0; m_tos = '0;
        end else begin
            m_ack = '0;
            if (m_ph == 0) begin
                m_wd = 0;
                if (rv != '0) begin
                    int g;
                    g = -1;
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && rv[(m_last + k) % N]) g = (m_last + k) % N;
                    m_last   = g;
                    m_hdr    = hdr[g];
                    m_ack[g] = 1'b1;
                    m_ph     = 1;
                end
            end else begin
                if (TO_EN && m_wd == TB_TO - 1) begin
                    m_ph = 0;
                    if (m_tos != 16'hFFFF) m_tos = m_tos + 16'd1;
                end else if (m_ph == 1 && gen_ready) begin
                    m_ph = 2;
                end else if (m_ph == 2 && tv && tr && tl) begin
                    m_ph = 0;
                    m_pkts = m_pkts + 32'd1;
                end
                m_wd++;
            end
        end
    endtask

    task automatic cmp_all();
        chk("req_ack", req_ack, m_ack);
        chk("ack_onehot0", ($countones(req_ack) <= 1), 1);
        chk("gen_hdr", gen_hdr, m_hdr);
        chk("gen_valid", gen_valid, (m_ph == 1));
        chk("busy", busy, (m_ph != 0));
        chk("grant_idx", grant_idx, m_last);
        chk("pkt_count", pkt_count, m_pkts);
        chk("timeout_count", timeout_count, m_tos);
        chk("gen_flush", gen_flush, (TO_EN && m_ph != 0 && m_wd == TB_TO - 1));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; gen_ready = 1'b0; tv = 1'b0; tr = 1'b0; tl = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic eop_beat();
        tv = 1'b1; tr = 1'b1; tl = 1'b1;
        step();
        tv = 1'b0; tr = 1'b0; tl = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        pkt_hdr_t saved;
        int       first_flush;
        int       n_flush;
        bit       seen;

        for (int i = 0; i < N; i++) hdr[i] = rand_hdr();

        // Reset state
        do_reset();
        chk("rst_grant_idx", grant_idx, N - 1);
        chk("rst_busy", busy, 0);
        chk("rst_gen_hdr", gen_hdr, 0);
        chk("rst_pkt_count", pkt_count, 0);

        // Single requester, generator ready
        rv = 4'b0001; gen_ready = 1'b1;
        step();
        rv = '0;
        chk("single_ack", req_ack, 4'b0001);
        chk("single_valid", gen_valid, 1);
        chk("single_hdr", gen_hdr, hdr[0]);
        step();
        chk("single_valid_drop", gen_valid, 0);
        chk("single_ack_drop", req_ack, 0);
        eop_beat();
        chk("single_pkt_count", pkt_count, 1);

        // All requesting: rotating order 0,1,2,3
        do_reset();
        rv = 4'b1111; gen_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                if (req_ack != '0) seen = 1'b1;
            end
            if (!seen) chk("rr_ack_wait", 0, 1);
            chk("rr_order", grant_idx, p);
            step();
            eop_beat();
        end
        rv = '0;
        chk("rr_pkt_count", pkt_count, 4);

        // Generator stalls for 10 cycles in ISSUE
        do_reset();
        rv = 4'b0001; gen_ready = 1'b0;
        step();
        rv = '0;
        saved  = gen_hdr;
        hdr[0] = rand_hdr();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_valid", gen_valid, 1);
            chk("stall_hdr", gen_hdr, saved);
        end
        gen_ready = 1'b1;
        step();
        chk("stall_release_valid", gen_valid, 0);
        chk("stall_release_busy", busy, 1);
        eop_beat();

        // End of packet with a new request in the same cycle
        do_reset();
        rv = 4'b0001; gen_ready = 1'b1;
        step();
        rv = '0;
        step();
        rv = 4'b0100;
        eop_beat();
        chk("eop_busy_gap", busy, 0);
        chk("eop_no_ack", req_ack, 0);
        step();
        rv = '0;
        chk("eop_regrant_busy", busy, 1);
        chk("eop_regrant_idx", grant_idx, 2);
        chk("eop_regrant_ack", req_ack, 4'b0100);
        step();
        eop_beat();

        // Watchdog: no tlast ever arrives
        do_reset();
        rv = 4'b0001; gen_ready = 1'b1;
        step();
        rv = '0;
        first_flush = -1;
        n_flush = 0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) step();
            if (gen_flush) begin
                n_flush++;
                if (first_flush < 0) first_flush = c;
            end
        end
        if (TO_EN) begin
            chk("wd_flush_cycle", first_flush, 15);
            chk("wd_flush_pulses", n_flush, 1);
            chk("wd_timeout_count", timeout_count, 1);
            chk("wd_busy_after", busy, 0);
        end else begin
            chk("nowd_flush_pulses", n_flush, 0);
            chk("nowd_busy_hold", busy, 1);
            chk("nowd_timeout_count", timeout_count, 0);
        end
        chk("wd_pkt_count", pkt_count, 0);

        // Reset in the middle of a packet
        do_reset();
        rv = 4'b0001; gen_ready = 1'b1;
        step();
        rv = '0;
        step();
        eop_beat();
        rv = 4'b0010;
        step();
        rv = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", gen_valid, 0);
        chk("midrst_ack", req_ack, 0);
        chk("midrst_flush", gen_flush, 0);
        chk("midrst_hdr", gen_hdr, 0);
        chk("midrst_grant_idx", grant_idx, N - 1);
        chk("midrst_pkt_count", pkt_count, 0);
        rv = 4'b0011;
        step();
        rv = '0;
        chk("midrst_next_grant", grant_idx, 0);
        chk("midrst_next_ack", req_ack, 4'b0001);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && ($urandom % 4 == 0)) begin
                    rv[i]  = 1'b1;
                    hdr[i] = rand_hdr();
                end
            end
            gen_ready = ($urandom % 4 != 0);
            tv  = $urandom % 2;
            tr  = $urandom % 2;
            tl  = ($urandom % 3 == 0);
            rst = ($urandom % 500 == 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) begin
                    if ($urandom % 2 == 0) rv[i] = 1'b0;
                    else hdr[i] = rand_hdr();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
